unified_mem_arbiter: RTL



---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/unified_mem_arbiter_if.sv | 48 ++++
 rtl/unified_mem_arbiter_rr_arb2.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the unified memory arbiter.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_rsp_valid;
   logic [DATA_W-1:0]     if_rsp_data;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_be;
   logic                  d_rsp_valid;
   logic [DATA_W-1:0]     d_rsp_data;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;

   // Arbiter side.
   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_we, d_addr, d_wdata, d_be,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata
   );

   // Requesters and memory macro side.
   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_we, d_addr, d_wdata, d_be,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata
   );

endinterface

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; the last winner only moves on an accepted request.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       hs_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = '0;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_q == REQ_D) ? 2'b01 : 2'b10;
         default: gnt_o = '0;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (hs_i) last_d = gnt_o[1] ? REQ_D : REQ_IF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= REQ_D;
      else        last_q <= last_d;
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and load/store,
// one transaction at a time with round-robin arbitration.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input logic        clk,
   input logic        rst_n,
   mem_arb_if.slave   bus
);

   localparam int unsigned          CNT_W    = cnt_width(MEM_LAT);
   localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

   state_t                 state_q;
   logic                   owner_q;
   logic                   we_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   mem_en_q;
   logic                   mem_we_q;
   logic [ADDR_W-1:0]      mem_addr_q;
   logic [DATA_W-1:0]      mem_wdata_q;
   logic [DATA_W/8-1:0]    mem_be_q;
   logic                   if_rsp_valid_q;
   logic                   d_rsp_valid_q;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       idle;
   logic       hs;
   logic       sel_d;

   assign req   = {bus.d_req_valid, bus.if_req_valid};
   // Ready is gated by rst_n so every output reads 0 while reset is held.
   assign idle  = rst_n && (state_q == IDLE);
   assign hs    = idle && (req != 2'b00);
   assign sel_d = gnt[REQ_D];

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req),
      .hs_i  (hs),
      .gnt_o (gnt)
   );

   assign bus.if_req_ready = idle && gnt[REQ_IF];
   assign bus.d_req_ready  = idle && gnt[REQ_D];
   assign bus.if_rsp_valid = if_rsp_valid_q;
   assign bus.d_rsp_valid  = d_rsp_valid_q;
   assign bus.if_rsp_data  = if_rsp_valid_q ? bus.mem_rdata : '0;
   assign bus.d_rsp_data   = (d_rsp_valid_q && !we_q) ? bus.mem_rdata : '0;
   assign bus.mem_en       = mem_en_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_be       = mem_be_q;

   // Memory-side registers double as the request latches; they hold only during ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= REQ_IF;
         we_q           <= 1'b0;
         cnt_q          <= '0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_be_q       <= '0;
         if_rsp_valid_q <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
      end else begin
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_be_q       <= '0;
         if_rsp_valid_q <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hs) begin
                  owner_q     <= sel_d;
                  we_q        <= sel_d && bus.d_we;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= sel_d && bus.d_we;
                  mem_addr_q  <= sel_d ? bus.d_addr  : bus.if_addr;
                  mem_wdata_q <= sel_d ? bus.d_wdata : '0;
                  mem_be_q    <= sel_d ? bus.d_be    : '0;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (MEM_LAT == 1) begin
                  state_q        <= RESP;
                  if_rsp_valid_q <= (owner_q == REQ_IF);
                  d_rsp_valid_q  <= (owner_q == REQ_D);
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= CNT_LOAD;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q        <= RESP;
                  if_rsp_valid_q <= (owner_q == REQ_IF);
                  d_rsp_valid_q  <= (owner_q == REQ_D);
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
